// File: rtl/tick_gen_pkg.sv
// Mode encodings shared by the tick generator and the game FSM.
package tick_gen_pkg;

  typedef enum logic [1:0] {
    MODE_FIXED  = 2'd0,
    MODE_LINEAR = 2'd1,
    MODE_GEOM   = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_t;

endpackage

// File: rtl/period_stepper.sv
// Combinational next-period computation for one ramp event, clamped at MIN_PERIOD.
module period_stepper
  import tick_gen_pkg::*;
#(
  parameter int PERIOD_W   = 20,
  parameter int MIN_PERIOD = 277777,
  parameter int STEP       = 5,
  parameter int SHIFT      = 6
) (
  input  logic [PERIOD_W-1:0] period_i,
  input  mode_t               mode_i,
  output logic [PERIOD_W-1:0] next_period_o
);

  localparam logic [PERIOD_W:0]   STEP_X = (PERIOD_W+1)'(STEP);
  localparam logic [PERIOD_W:0]   MIN_X  = (PERIOD_W+1)'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] MIN_P  = PERIOD_W'(MIN_PERIOD);

  logic [PERIOD_W-1:0] geom_dec;
  logic [PERIOD_W:0]   dec;
  logic [PERIOD_W:0]   diff;

  always_comb begin
    geom_dec = period_i >> SHIFT;
    if (geom_dec == '0) begin
      geom_dec = PERIOD_W'(1);
    end

    case (mode_i)
      MODE_LINEAR: dec = STEP_X;
      MODE_GEOM:   dec = {1'b0, geom_dec};
      default:     dec = '0;
    endcase

    // One extra bit so a decrement larger than P shows up as a borrow.
    diff = {1'b0, period_i} - dec;

    if (diff[PERIOD_W] || (diff < MIN_X)) begin
      next_period_o = MIN_P;
    end else begin
      next_period_o = diff[PERIOD_W-1:0];
    end
  end

endmodule

// File: rtl/ramped_tick_generator.sv
// Tick strobe generator whose period ramps from START_PERIOD toward MIN_PERIOD.
module ramped_tick_generator
  import tick_gen_pkg::*;
#(
  parameter int PERIOD_W     = 20,
  parameter int START_PERIOD = 833333,
  parameter int MIN_PERIOD   = 277777,
  parameter int STEP         = 5,
  parameter int SHIFT        = 6,
  parameter int RAMP_EVERY   = 1,
  parameter int RAMP_CNT_W   = 8,
  parameter int TICK_CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  pause,
  input  logic                  restart,
  input  mode_t                 mode,
  output logic                  tick,
  output logic [PERIOD_W-1:0]   period,
  output logic                  at_max_speed,
  output logic [TICK_CNT_W-1:0] tick_count
);

  localparam logic [PERIOD_W-1:0]   START_P    = PERIOD_W'(START_PERIOD);
  localparam logic [PERIOD_W-1:0]   MIN_P      = PERIOD_W'(MIN_PERIOD);
  localparam logic [RAMP_CNT_W-1:0] RAMP_LAST  = RAMP_CNT_W'(RAMP_EVERY - 1);
  localparam logic                  AT_MAX_RST = (START_PERIOD == MIN_PERIOD);

  logic [PERIOD_W-1:0]   cnt_q, cnt_d;
  logic [PERIOD_W-1:0]   period_q, period_d;
  logic [RAMP_CNT_W-1:0] ramp_cnt_q, ramp_cnt_d;
  logic                  tick_q, tick_d;
  logic [TICK_CNT_W-1:0] tick_count_q, tick_count_d;
  logic                  at_max_q, at_max_d;
  logic [PERIOD_W-1:0]   period_next;
  logic                  terminal;

  period_stepper #(
    .PERIOD_W   (PERIOD_W),
    .MIN_PERIOD (MIN_PERIOD),
    .STEP       (STEP),
    .SHIFT      (SHIFT)
  ) u_stepper (
    .period_i      (period_q),
    .mode_i        (mode),
    .next_period_o (period_next)
  );

  assign terminal = (cnt_q == (period_q - PERIOD_W'(1)));

  always_comb begin
    cnt_d        = cnt_q;
    period_d     = period_q;
    ramp_cnt_d   = ramp_cnt_q;
    tick_d       = 1'b0;
    tick_count_d = tick_count_q;

    if (restart) begin
      cnt_d        = '0;
      period_d     = START_P;
      ramp_cnt_d   = '0;
      tick_count_d = '0;
    end else if (!enable) begin
      cnt_d = '0;
    end else if (pause) begin
      cnt_d = cnt_q;
    end else if (terminal) begin
      cnt_d        = '0;
      tick_d       = 1'b1;
      tick_count_d = tick_count_q + TICK_CNT_W'(1);
      // The stepped period takes over for the interval that starts now.
      if (ramp_cnt_q == RAMP_LAST) begin
        ramp_cnt_d = '0;
        period_d   = period_next;
      end else begin
        ramp_cnt_d = ramp_cnt_q + RAMP_CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q + PERIOD_W'(1);
    end

    at_max_d = (period_d == MIN_P);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      period_q     <= START_P;
      ramp_cnt_q   <= '0;
      tick_q       <= 1'b0;
      tick_count_q <= '0;
      at_max_q     <= AT_MAX_RST;
    end else begin
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      ramp_cnt_q   <= ramp_cnt_d;
      tick_q       <= tick_d;
      tick_count_q <= tick_count_d;
      at_max_q     <= at_max_d;
    end
  end

  assign tick         = tick_q;
  assign period       = period_q;
  assign at_max_speed = at_max_q;
  assign tick_count   = tick_count_q;

endmodule
